// File: rtl/background_redraw_controller.sv
// Background redraw controller: walks a full-screen or clipped rectangular region of the
// background ROM and streams the returned pixels to the VGA adapter as plot writes.
module background_redraw_controller #(
   parameter int unsigned SCREEN_W    = 320,
   parameter int unsigned SCREEN_H    = 240,
   parameter int unsigned ROM_LATENCY = 1
) (
   input  logic       clock,
   input  logic       resetn,
   input  logic [3:0] gameState,
   input  logic       start_rect,
   input  logic [8:0] rect_x,
   input  logic [7:0] rect_y,
   input  logic [8:0] rect_w,
   input  logic [7:0] rect_h,
   output logic [8:0] bg_x,
   output logic [7:0] bg_y,
   input  logic [2:0] bg_color,
   output logic [8:0] vga_x,
   output logic [7:0] vga_y,
   output logic [2:0] vga_colour,
   output logic       vga_plot,
   output logic       busy,
   output logic       done
);
   localparam int unsigned XW = 9;
   localparam int unsigned YW = 8;
   localparam int unsigned SW = 4;
   localparam logic [XW:0] SCR_W = (XW+1)'(SCREEN_W);
   localparam logic [YW:0] SCR_H = (YW+1)'(SCREEN_H);

   typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_e;

   state_e          state_q, state_d;
   logic [XW-1:0]   cur_x_q, cur_x_d, x0_q, x0_d, x_end_q, x_end_d, bg_x_q, bg_x_d;
   logic [YW-1:0]   cur_y_q, cur_y_d, y_end_q, y_end_d, bg_y_q, bg_y_d;
   logic [SW-1:0]   prev_state_q, prev_state_d;
   logic            pending_q, pending_d;
   logic            issue_v_q, issue_v_d;
   logic            busy_q, busy_d, done_q, done_d;

   logic [ROM_LATENCY-1:0] sr_v_q;
   logic [XW-1:0]          sr_x_q [ROM_LATENCY];
   logic [YW-1:0]          sr_y_q [ROM_LATENCY];
   logic [XW-1:0]          vga_x_q;
   logic [YW-1:0]          vga_y_q;
   logic [2:0]             vga_colour_q;
   logic                   vga_plot_q;

   logic [XW:0] rect_x_sum, rect_x_lim;
   logic [YW:0] rect_y_sum, rect_y_lim;
   logic        rect_empty, scan_last, pipe_empty;

   // Rectangle clipping; sums are one bit wider than the operands so they cannot wrap.
   always_comb begin
      rect_x_sum = (XW+1)'(rect_x) + (XW+1)'(rect_w);
      rect_y_sum = (YW+1)'(rect_y) + (YW+1)'(rect_h);
      rect_x_lim = (rect_x_sum > SCR_W) ? SCR_W : rect_x_sum;
      rect_y_lim = (rect_y_sum > SCR_H) ? SCR_H : rect_y_sum;
      rect_empty = (rect_w == '0) || (rect_h == '0) ||
                   ((XW+1)'(rect_x) >= SCR_W) || ((YW+1)'(rect_y) >= SCR_H);
      scan_last  = (cur_x_q == x_end_q) && (cur_y_q == y_end_q);
      pipe_empty = !issue_v_q && (sr_v_q == '0);
   end

   // Next-state and registered-output logic.
   always_comb begin
      state_d      = state_q;
      cur_x_d      = cur_x_q;
      cur_y_d      = cur_y_q;
      x0_d         = x0_q;
      x_end_d      = x_end_q;
      y_end_d      = y_end_q;
      prev_state_d = prev_state_q;
      pending_d    = pending_q;
      bg_x_d       = bg_x_q;
      bg_y_d       = bg_y_q;
      issue_v_d    = 1'b0;
      unique case (state_q)
         IDLE: begin
            // Full redraw wins over a simultaneous rect request, which it already covers.
            if (pending_q || (gameState != prev_state_q)) begin
               state_d      = SCAN;
               cur_x_d      = '0;
               cur_y_d      = '0;
               x0_d         = '0;
               x_end_d      = XW'(SCREEN_W - 1);
               y_end_d      = YW'(SCREEN_H - 1);
               prev_state_d = gameState;
               pending_d    = 1'b0;
            end else if (start_rect) begin
               state_d      = rect_empty ? DONE : SCAN;
               cur_x_d      = rect_x;
               cur_y_d      = rect_y;
               x0_d         = rect_x;
               x_end_d      = XW'(rect_x_lim - (XW+1)'(1));
               y_end_d      = YW'(rect_y_lim - (YW+1)'(1));
               prev_state_d = gameState;
               pending_d    = 1'b0;
            end
         end
         SCAN: begin
            bg_x_d    = cur_x_q;
            bg_y_d    = cur_y_q;
            issue_v_d = 1'b1;
            if (scan_last) begin
               state_d = DRAIN;
            end else if (cur_x_q == x_end_q) begin
               cur_x_d = x0_q;
               cur_y_d = cur_y_q + YW'(1);
            end else begin
               cur_x_d = cur_x_q + XW'(1);
            end
         end
         DRAIN: begin
            if (pipe_empty) state_d = DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
      endcase
      // A state change during a redraw is remembered and served from IDLE afterwards.
      if ((state_q != IDLE) && (gameState != prev_state_q)) pending_d = 1'b1;
      busy_d = (state_d != IDLE);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q      <= IDLE;
         cur_x_q      <= '0;
         cur_y_q      <= '0;
         x0_q         <= '0;
         x_end_q      <= '0;
         y_end_q      <= '0;
         prev_state_q <= 4'hF;
         pending_q    <= 1'b0;
         bg_x_q       <= '0;
         bg_y_q       <= '0;
         issue_v_q    <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cur_x_q      <= cur_x_d;
         cur_y_q      <= cur_y_d;
         x0_q         <= x0_d;
         x_end_q      <= x_end_d;
         y_end_q      <= y_end_d;
         prev_state_q <= prev_state_d;
         pending_q    <= pending_d;
         bg_x_q       <= bg_x_d;
         bg_y_q       <= bg_y_d;
         issue_v_q    <= issue_v_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   // Coordinate delay line aligning each issued address with its ROM colour.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         sr_v_q       <= '0;
         vga_x_q      <= '0;
         vga_y_q      <= '0;
         vga_colour_q <= '0;
         vga_plot_q   <= 1'b0;
         for (int i = 0; i < ROM_LATENCY; i++) begin
            sr_x_q[i] <= '0;
            sr_y_q[i] <= '0;
         end
      end else begin
         sr_v_q[0] <= issue_v_q;
         sr_x_q[0] <= bg_x_q;
         sr_y_q[0] <= bg_y_q;
         for (int i = 1; i < ROM_LATENCY; i++) begin
            sr_v_q[i] <= sr_v_q[i-1];
            sr_x_q[i] <= sr_x_q[i-1];
            sr_y_q[i] <= sr_y_q[i-1];
         end
         vga_plot_q <= sr_v_q[ROM_LATENCY-1];
         if (sr_v_q[ROM_LATENCY-1]) begin
            vga_x_q      <= sr_x_q[ROM_LATENCY-1];
            vga_y_q      <= sr_y_q[ROM_LATENCY-1];
            vga_colour_q <= bg_color;
         end
      end
   end

   assign bg_x       = bg_x_q;
   assign bg_y       = bg_y_q;
   assign vga_x      = vga_x_q;
   assign vga_y      = vga_y_q;
   assign vga_colour = vga_colour_q;
   assign vga_plot   = vga_plot_q;
   assign busy       = busy_q;
   assign done       = done_q;

endmodule

// File: tb/tb_background_redraw_controller.sv
// Bench for background_redraw_controller: two instances (ROM latency 1 and 3) on a reduced
// screen share stimulus; a scoreboard per instance checks every plot, done pulse and latency.
module tb_background_redraw_controller;
   localparam int W      = 40;
   localparam int H      = 30;
   localparam int N_FULL = W * H;
   localparam int P_CHG  = 100;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       resetn, start_rect;
   logic [3:0] gameState;
   logic [8:0] rect_x, rect_w;
   logic [7:0] rect_y, rect_h;
   logic [8:0] bg_x_w [2];
   logic [7:0] bg_y_w [2];
   logic [8:0] vga_x_w [2];
   logic [7:0] vga_y_w [2];
   logic [2:0] vga_col_w [2];
   logic       plot_w [2];
   logic       busy_w [2];
   logic       done_w [2];
   logic [2:0] rom1_q;
   logic [2:0] rom3_q [3];

   background_redraw_controller #(.SCREEN_W(W), .SCREEN_H(H), .ROM_LATENCY(1)) u_dut1 (
      .clock(clk), .resetn(resetn), .gameState(gameState), .start_rect(start_rect),
      .rect_x(rect_x), .rect_y(rect_y), .rect_w(rect_w), .rect_h(rect_h),
      .bg_x(bg_x_w[0]), .bg_y(bg_y_w[0]), .bg_color(rom1_q),
      .vga_x(vga_x_w[0]), .vga_y(vga_y_w[0]), .vga_colour(vga_col_w[0]),
      .vga_plot(plot_w[0]), .busy(busy_w[0]), .done(done_w[0]));

   background_redraw_controller #(.SCREEN_W(W), .SCREEN_H(H), .ROM_LATENCY(3)) u_dut3 (
      .clock(clk), .resetn(resetn), .gameState(gameState), .start_rect(start_rect),
      .rect_x(rect_x), .rect_y(rect_y), .rect_w(rect_w), .rect_h(rect_h),
      .bg_x(bg_x_w[1]), .bg_y(bg_y_w[1]), .bg_color(rom3_q[2]),
      .vga_x(vga_x_w[1]), .vga_y(vga_y_w[1]), .vga_colour(vga_col_w[1]),
      .vga_plot(plot_w[1]), .busy(busy_w[1]), .done(done_w[1]));

   function automatic logic [2:0] rom_col(input logic [3:0] st, input logic [8:0] x,
                                          input logic [7:0] y);
      int v;
      v = int'(x) * 3 + int'(y) * 5 + int'(st) * 7 + (int'(x) >> 2);
      return 3'(v ^ (v >> 3));
   endfunction

   // Background ROM models, state-selected, latency 1 and 3.
   always @(posedge clk) begin
      rom1_q    <= rom_col(gameState, bg_x_w[0], bg_y_w[0]);
      rom3_q[0] <= rom_col(gameState, bg_x_w[1], bg_y_w[1]);
      rom3_q[1] <= rom3_q[0];
      rom3_q[2] <= rom3_q[1];
   end

   int          checks = 0, errors = 0, cyc = 0, exp_done = 0;
   int          done_cnt [2] = '{0, 0};
   int          done_cyc [2] = '{0, 0};
   int          prev_done_cyc [2] = '{0, 0};
   int          first_cyc [2] = '{0, 0};
   bit          arm [2] = '{1'b0, 1'b0};
   bit          prev_done [2] = '{1'b0, 1'b0};
   logic [19:0] exp_q [2][$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: pops the scoreboard on every plot and polices done/busy behaviour.
   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (!resetn) begin
            prev_done[d] = 1'b0;
         end else begin
            if (plot_w[d]) begin
               if (arm[d]) begin
                  first_cyc[d] = cyc;
                  arm[d]       = 1'b0;
               end
               if (exp_q[d].size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL plot_extra dut%0d: got plot (%0d,%0d) required none",
                           d, vga_x_w[d], vga_y_w[d]);
               end else begin
                  chk($sformatf("plot dut%0d", d), {vga_x_w[d], vga_y_w[d], vga_col_w[d]},
                      exp_q[d].pop_front());
               end
            end
            if (prev_done[d]) begin
               chk($sformatf("busy_after_done dut%0d", d), busy_w[d], 0);
               chk($sformatf("done_width dut%0d", d), done_w[d], 0);
            end
            if (done_w[d]) begin
               chk($sformatf("busy_at_done dut%0d", d), busy_w[d], 1);
               done_cnt[d]++;
               prev_done_cyc[d] = done_cyc[d];
               done_cyc[d]      = cyc;
            end
            prev_done[d] = done_w[d];
         end
      end
   end

   task automatic push_px(input int x, input int y, input logic [3:0] st);
      for (int d = 0; d < 2; d++) exp_q[d].push_back({9'(x), 8'(y), rom_col(st, 9'(x), 8'(y))});
   endtask

   // Full screen in row-major order; pixels from index split onward see state st_b.
   task automatic push_full(input logic [3:0] st_a, input logic [3:0] st_b, input int split);
      for (int k = 0; k < N_FULL; k++) push_px(k % W, k / W, (k < split) ? st_a : st_b);
   endtask

   task automatic push_rect(input int rx, input int ry, input int rw, input int rh,
                            input logic [3:0] st, output int n);
      int xe, ye;
      n = 0;
      if (rw == 0 || rh == 0 || rx >= W || ry >= H) return;
      xe = (rx + rw < W) ? rx + rw : W;
      ye = (ry + rh < H) ? ry + rh : H;
      for (int y = ry; y < ye; y++)
         for (int x = rx; x < xe; x++) begin
            push_px(x, y, st);
            n++;
         end
   endtask

   task automatic arm_both();
      for (int d = 0; d < 2; d++) begin
         arm[d]       = 1'b1;
         first_cyc[d] = -100000;
      end
   endtask

   task automatic wait_done(input int target);
      int i = 0;
      while ((done_cnt[0] < target || done_cnt[1] < target) && i < 5000) begin
         @(negedge clk);
         i++;
      end
      chk("done_reached", (done_cnt[0] >= target && done_cnt[1] >= target), 1);
      repeat (2) @(negedge clk);
   endtask

   task automatic chk_timing(input string tag, input int s, input int n);
      chk({tag, " first_plot L1"}, first_cyc[0] - s, 3);
      chk({tag, " first_plot L3"}, first_cyc[1] - s, 5);
      chk({tag, " done L1"}, done_cyc[0] - s, n + 3);
      chk({tag, " done L3"}, done_cyc[1] - s, n + 5);
   endtask

   task automatic chk_drained(input string tag);
      for (int d = 0; d < 2; d++) chk($sformatf("%s drained dut%0d", tag, d), exp_q[d].size(), 0);
   endtask

   task automatic do_rect(input int rx, input int ry, input int rw, input int rh);
      int n, s;
      push_rect(rx, ry, rw, rh, gameState, n);
      if (n > 0) arm_both();
      rect_x     = 9'(rx);
      rect_y     = 8'(ry);
      rect_w     = 9'(rw);
      rect_h     = 8'(rh);
      start_rect = 1'b1;
      s          = cyc + 1;
      @(negedge clk);
      start_rect = 1'b0;
      exp_done++;
      wait_done(exp_done);
      if (n > 0) chk_timing($sformatf("rect(%0d,%0d,%0d,%0d)", rx, ry, rw, rh), s, n);
      chk_drained("rect");
   endtask

   initial begin
      int s;
      resetn = 1'b0; gameState = 4'd0; start_rect = 1'b0;
      rect_x = '0; rect_y = '0; rect_w = '0; rect_h = '0;
      repeat (3) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("rst plot dut%0d", d), plot_w[d], 0);
         chk($sformatf("rst busy dut%0d", d), busy_w[d], 0);
         chk($sformatf("rst done dut%0d", d), done_w[d], 0);
         chk($sformatf("rst coords dut%0d", d), {bg_x_w[d], bg_y_w[d], vga_x_w[d], vga_y_w[d]}, 0);
      end

      // Reset release: automatic full redraw with state 0.
      push_full(4'd0, 4'd0, N_FULL);
      arm_both();
      s      = cyc + 1;
      resetn = 1'b1;
      exp_done = 1;
      wait_done(exp_done);
      chk_timing("full_after_reset", s, N_FULL);
      chk_drained("full_after_reset");

      // Directed rectangles, clipping and empty cases, then random ones.
      do_rect(10, 20, 4, 3);
      do_rect(W - 2, H - 2, 5, 5);
      do_rect(5, 5, 0, 3);
      do_rect(W, 2, 4, 4);
      do_rect(3, H, 4, 4);
      do_rect(30, 25, 500, 200);
      for (int i = 0; i < 10; i++)
         do_rect($urandom_range(0, W + 3), $urandom_range(0, H + 3),
                 ($urandom_range(0, 3) == 0) ? $urandom_range(0, 511) : $urandom_range(0, 8),
                 ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 6));

      // Asynchronous reset mid-scan of a state-3 full redraw.
      gameState = 4'd3;
      push_full(4'd3, 4'd3, N_FULL);
      repeat (300) @(negedge clk);
      #2 resetn = 1'b0;
      #1;
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("async_rst plot dut%0d", d), plot_w[d], 0);
         chk($sformatf("async_rst busy dut%0d", d), busy_w[d], 0);
         exp_q[d].delete();
      end
      gameState = 4'd0;
      @(negedge clk);

      // Restart from (0,0); state changes 0->1 at pixel P_CHG, forcing a second full redraw.
      push_full(4'd0, 4'd1, P_CHG);
      push_full(4'd1, 4'd1, N_FULL);
      arm_both();
      s      = cyc + 1;
      resetn = 1'b1;
      repeat (P_CHG + 2) @(posedge clk);
      @(negedge clk);
      gameState = 4'd1;
      exp_done += 2;
      wait_done(exp_done);
      chk("restart first_plot L1", first_cyc[0] - s, 3);
      chk("restart first_plot L3", first_cyc[1] - s, 5);
      chk("restart done L1", prev_done_cyc[0] - s, N_FULL + 3);
      chk("restart done L3", prev_done_cyc[1] - s, N_FULL + 5);
      chk("back_to_back gap L1", done_cyc[0] - prev_done_cyc[0], N_FULL + 5);
      chk("back_to_back gap L3", done_cyc[1] - prev_done_cyc[1], N_FULL + 7);
      chk_drained("back_to_back");

      // Rect and state change together: only the full redraw runs; rect while busy is ignored.
      gameState  = 4'd2;
      rect_x = 9'd1; rect_y = 8'd1; rect_w = 9'd3; rect_h = 8'd3;
      start_rect = 1'b1;
      push_full(4'd2, 4'd2, N_FULL);
      arm_both();
      s = cyc + 1;
      @(negedge clk);
      start_rect = 1'b0;
      repeat (50) @(negedge clk);
      rect_x = 9'd0; rect_y = 8'd0; rect_w = 9'd5; rect_h = 8'd5;
      start_rect = 1'b1;
      @(negedge clk);
      start_rect = 1'b0;
      exp_done++;
      wait_done(exp_done);
      chk_timing("full_priority", s, N_FULL);
      repeat (20) @(negedge clk);
      chk_drained("full_priority");
      chk("done_count L1", done_cnt[0], exp_done);
      chk("done_count L3", done_cnt[1], exp_done);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/background_redraw_controller.md
# background_redraw_controller

Sequences pixel fetches from the background pixel lookup (gameState-selected background ROMs, 320x240, 3-bit colour) and streams the results to the VGA adapter as plot writes. Supports two redraw kinds: full-screen redraws, triggered automatically on every gameState change, and rectangular patch redraws used to erase sprites. It sits between the game FSM, the sprite drawer and the VGA adapter, and is the only block that drives the background lookup's X/Y inputs.

## Interface
- SCREEN_W, 320, screen width in pixels
- SCREEN_H, 240, screen height in pixels
- ROM_LATENCY, 1, clocks from bg_x/bg_y valid to the matching bg_color valid (range 1–4)

- clock  in  1  system clock, rising edge
- resetn  in  1  asynchronous, active-low reset
- gameState  in  4  current game state; any change requests a full redraw
- start_rect  in  1  single-cycle request for a rectangle redraw
- rect_x, rect_y  in  9/8  top-left corner of the rectangle
- rect_w, rect_h  in  9/8  rectangle size in pixels
- bg_x, bg_y  out  9/8  coordinate driven to the background lookup
- bg_color  in  3  colour returned by the lookup
- vga_x, vga_y  out  9/8  plot coordinate
- vga_colour  out  3  plot colour
- vga_plot  out  1  write strobe
- busy  out  1  high while a redraw is in progress
- done  out  1  one-cycle pulse when a redraw completes

## Operation
- States: IDLE, SCAN, DRAIN, DONE.
- Reset values:
  - All outputs are 0.
  - The pending_full flag is cleared.
  - prev_state resets to 4'hF, so the first clock after reset always sees a "change" and starts a full redraw.
- IDLE:
  - If pending_full is set, or gameState differs from prev_state, start a full redraw over region (0,0)–(SCREEN_W-1, SCREEN_H-1).
  - Otherwise, if start_rect is high, latch the rectangle and start a rect redraw.
  - Full redraw has priority when both occur in the same cycle. The rect request is then dropped, because the full redraw covers it.
  - Starting a redraw loads prev_state with gameState and clears pending_full.
- Rect clipping:
  - x_end = min(rect_x + rect_w, SCREEN_W) - 1; y_end = min(rect_y + rect_h, SCREEN_H) - 1. Compute with 10-bit and 9-bit sums so no overflow occurs.
  - If rect_w == 0, rect_h == 0, rect_x >= SCREEN_W or rect_y >= SCREEN_H, go directly to DONE with zero plots.
- SCAN:
  - Issue one coordinate per clock in row-major order (x fastest), from (x0,y0) to (x_end,y_end).
  - Each issued coordinate enters a ROM_LATENCY-deep shift register together with a valid bit.
  - After the last coordinate is issued, go to DRAIN.
- Pipeline output: when the shift-register output is valid, register vga_x/vga_y from the delayed coordinate and vga_colour from bg_color, and assert vga_plot for one cycle. Exactly one plot is produced per issued coordinate.
- DRAIN: stay until the pipeline is empty, then go to DONE.
- DONE: pulse done for one cycle, then return to IDLE.
- gameState change while busy: set pending_full. Do not abort the current redraw; the restart happens from IDLE on the next cycle.
- start_rect while busy is ignored. The requester must wait for done and retry.
- bg_x/bg_y hold their last value when not scanning.
- busy is high in SCAN, DRAIN and DONE.

## Timing
- A request sampled in IDLE at edge S causes the first bg_x/bg_y to be valid after edge S+1.
- Matching vga_plot is high ROM_LATENCY+1 cycles after its coordinate is issued (ROM latency plus the output register).
- For N pixels with L = ROM_LATENCY:
  - coordinates are issued in cycles S+1 … S+N;
  - the last vga_plot is at cycle S+N+L+1;
  - done is high at cycle S+N+L+2;
  - IDLE resumes the following cycle.
- Full-screen redraw: N = 76800.
- Sustained throughput is one plot per clock, with no bubbles inside a redraw.
- Back-to-back redraws (pending_full set) have a 1-cycle IDLE gap after done.
- Asynchronous reset mid-redraw:
  - immediately clears vga_plot, busy, done and the pipeline valid bits;
  - after release, a full redraw starts on the first clock.

## Test plan
- Reset release with gameState=0, ROM_LATENCY=1:
  - first plot at (0,0);
  - 76800 plots in row-major order;
  - last plot at (319,239);
  - done is a single pulse 76803 cycles after the start edge;
  - every plot colour equals the ROM model's value at its coordinate.
- Idle, start_rect with (10,20,4,3):
  - 12 plots, in order (10,20)…(13,20),(10,21)…(13,22);
  - busy deasserts the cycle after done.
- Edge clipping, rect (318,238,5,5): exactly 4 plots, at (318,238),(319,238),(318,239),(319,239). Rect w=0: zero plots and one done pulse.
- gameState changes 0→1 at pixel 1000 of a full redraw:
  - the current redraw completes with 76800 plots;
  - after one IDLE cycle a second full redraw runs with state-1 colours.
- start_rect and a gameState change in the same IDLE cycle: only the full redraw runs. start_rect while busy: no extra plots.
- Assert resetn low mid-scan:
  - vga_plot and busy drop to 0 asynchronously;
  - after release, the full redraw restarts from (0,0).
- Repeat the first scenario with ROM_LATENCY=3: plot colours still match coordinates, and done arrives at S+76805.
